// File: rtl/hazard_controller.sv
// Pipeline hazard controller: RAW stall detection, branch flush sequencing,
// data-memory wait freezing with a watchdog, and saturating stall/flush counters.
module hazard_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [3:0]       id_src_1,
    input  logic [3:0]       id_src_2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic             freeze_pipe,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {RUN, HAZ_STALL, MEM_WAIT, ERROR} state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_next;
    logic              stall_inc, flush_inc;
    logic              hazard, mem_wait;

    // With forwarding only a load in EXE is unresolvable; without it any
    // in-flight writer in EXE or MEM blocks the read.
    function automatic logic haz(input logic [3:0] s);
        if (fwd_en)
            haz = (s == exe_dest) && exe_wb_en && exe_mem_r_en;
        else
            haz = ((s == exe_dest) && exe_wb_en) || ((s == mem_dest) && mem_wb_en);
    endfunction

    always_comb begin
        hazard   = id_valid && (haz(id_src_1) || (id_two_src && haz(id_src_2)));
        mem_wait = mem_req && !mem_ready;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // branches below leaves a signal unassigned and infers a latch.
        freeze_pc    = 1'b0;
        freeze_if_id = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        freeze_pipe  = 1'b0;
        mem_timeout  = 1'b0;
        next_state   = RUN;
        wait_next    = '0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (state == ERROR) begin
            freeze_pipe = 1'b1;
            mem_timeout = 1'b1;
            next_state  = ERROR;
            wait_next   = wait_cnt;
        end else if (mem_wait) begin
            freeze_pipe = 1'b1;
            wait_next   = wait_cnt + 1'b1;
            next_state  = (wait_cnt == WAIT_LAST) ? ERROR : MEM_WAIT;
        end else if (branch_taken) begin
            // The ID instruction is squashed, so its hazard is irrelevant.
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
            flush_inc    = 1'b1;
        end else if (hazard) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            flush_id_exe = 1'b1;
            stall_inc    = 1'b1;
            next_state   = HAZ_STALL;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller: one MAX_WAIT=4 instance
// for control/watchdog behaviour and one CNT_W=2 instance for counter saturation.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en, id_valid, id_two_src;
    logic [3:0]  id_src_1, id_src_2, exe_dest, mem_dest;
    logic        exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic        branch_taken, mem_req, mem_ready;

    logic        freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_pipe, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_freeze_pc, s_freeze_if_id, s_flush_if_id, s_flush_id_exe, s_freeze_pipe, s_mem_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_controller #(.MAX_WAIT(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_src_1(id_src_1), .id_src_2(id_src_2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
        .flush_id_exe(flush_id_exe), .freeze_pipe(freeze_pipe), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_controller #(.MAX_WAIT(16), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_src_1(id_src_1), .id_src_2(id_src_2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(s_freeze_pc), .freeze_if_id(s_freeze_if_id), .flush_if_id(s_flush_if_id),
        .flush_id_exe(s_flush_id_exe), .freeze_pipe(s_freeze_pipe), .mem_timeout(s_mem_timeout),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Control vector order: freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_pipe, mem_timeout
    function automatic logic [5:0] ctl();
        ctl = {freeze_pc, freeze_if_id, flush_if_id, flush_id_exe, freeze_pipe, mem_timeout};
    endfunction

    function automatic logic [5:0] s_ctl();
        s_ctl = {s_freeze_pc, s_freeze_if_id, s_flush_if_id, s_flush_id_exe, s_freeze_pipe, s_mem_timeout};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        fwd_en = 1'b1; id_valid = 1'b0; id_two_src = 1'b0;
        id_src_1 = 4'd0; id_src_2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Move to the falling edge so new inputs settle well away from the active edge.
    task automatic to_negedge();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        to_negedge(); rst = 1'b1; #1;
        check("reset_ctl", 32'(ctl()), 32'h00);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_flush_cnt", 32'(flush_cnt), 32'd0);

        // 1: load-use with forwarding costs one stall cycle
        fwd_en = 1'b1; id_valid = 1'b1; id_src_1 = 4'd3; id_src_2 = 4'd9;
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; #1;
        check("t1_load_use_stall", 32'(ctl()), 32'b110100);
        to_negedge();
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = 4'd3; mem_wb_en = 1'b1; #1;
        check("t1_bubble_release", 32'(ctl()), 32'h00);
        check("t1_stall_cnt", 32'(stall_cnt), 32'd1);

        // 2: no forwarding, src_2 dependency stalls through EXE and MEM
        to_negedge();
        fwd_en = 1'b0; id_src_1 = 4'd1; id_src_2 = 4'd5; id_two_src = 1'b1;
        exe_dest = 4'd5; exe_wb_en = 1'b1; mem_dest = 4'd7; mem_wb_en = 1'b1; #1;
        check("t2_stall_exe", 32'(ctl()), 32'b110100);
        to_negedge();
        exe_wb_en = 1'b0; mem_dest = 4'd5; mem_wb_en = 1'b1; #1;
        check("t2_stall_mem", 32'(ctl()), 32'b110100);
        to_negedge();
        mem_wb_en = 1'b0; #1;
        check("t2_release", 32'(ctl()), 32'h00);
        check("t2_stall_cnt", 32'(stall_cnt), 32'd3);
        exe_dest = 4'd5; exe_wb_en = 1'b1; id_two_src = 1'b0; #1;
        check("t2_single_src_no_stall", 32'(ctl()), 32'h00);

        // 3: branch overrides a simultaneous load-use hazard
        to_negedge();
        fwd_en = 1'b1; id_two_src = 1'b0; id_src_1 = 4'd4; exe_dest = 4'd4;
        exe_wb_en = 1'b1; exe_mem_r_en = 1'b1; branch_taken = 1'b1; #1;
        check("t3_branch_flush", 32'(ctl()), 32'b001100);
        to_negedge();
        idle_inputs(); #1;
        check("t3_flush_cnt", 32'(flush_cnt), 32'd1);
        check("t3_stall_cnt_held", 32'(stall_cnt), 32'd3);

        // 4: three wait cycles with a pending branch, then release with flush
        for (int i = 0; i < 3; i++) begin
            if (i != 0) to_negedge();
            mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1; #1;
            check($sformatf("t4_wait_%0d", i), 32'(ctl()), 32'b000010);
        end
        to_negedge();
        mem_ready = 1'b1; #1;
        check("t4_release_flush", 32'(ctl()), 32'b001100);
        to_negedge();
        idle_inputs(); #1;
        check("t4_flush_cnt", 32'(flush_cnt), 32'd2);
        check("t4_no_timeout", 32'(ctl()), 32'h00);

        // 5: watchdog trips after MAX_WAIT=4 wait cycles
        for (int i = 0; i < 4; i++) begin
            if (i != 0) to_negedge();
            mem_req = 1'b1; mem_ready = 1'b0; #1;
            check($sformatf("t5_wait_%0d", i), 32'(ctl()), 32'b000010);
        end
        to_negedge();
        #1;
        check("t5_error_entered", 32'(ctl()), 32'b000011);
        to_negedge();
        mem_req = 1'b0; branch_taken = 1'b1; #1;
        check("t5_error_sticky", 32'(ctl()), 32'b000011);
        check("t5_error_no_flush_count", 32'(flush_cnt), 32'd2);
        to_negedge();
        idle_inputs(); rst = 1'b0;
        to_negedge();
        rst = 1'b1; #1;
        check("t5_reset_ctl", 32'(ctl()), 32'h00);
        check("t5_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("t5_reset_flush_cnt", 32'(flush_cnt), 32'd0);

        // 6: 2-bit stall counter saturates, then reset mid-stall clears it
        fwd_en = 1'b0; id_valid = 1'b1; id_src_1 = 4'd6; exe_dest = 4'd6; exe_wb_en = 1'b1; #1;
        check("t6_sat_start", 32'(s_stall_cnt), 32'd0);
        for (int i = 0; i < 5; i++) begin
            to_negedge();
            #1;
            check($sformatf("t6_sat_cnt_%0d", i), 32'(s_stall_cnt), (i < 2) ? 32'(i + 1) : 32'd3);
        end
        check("t6_still_stalling", 32'(s_ctl()), 32'b110100);
        rst = 1'b0;
        to_negedge();
        rst = 1'b1; id_valid = 1'b0; #1;
        check("t6_reset_ctl", 32'(s_ctl()), 32'h00);
        check("t6_reset_stall_cnt", 32'(s_stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
